riscv_apu_arbiter: RTL and testbench

Shares one APU interconnect port between NUM_REQ core-side APU dispatchers. Each cycle, a round-robin arbiter picks one requester and forwards its request to the interconnect. Accepted requests are tagged with their requester ID in an in-order tracking FIFO. Each response from the interconnect is routed back to the requester that issued it, together with that instruction's destination register address.

---
 rtl/riscv_apu_arbiter.sv | 127 ++++++++++++
 tb/tb_riscv_apu_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_apu_arbiter.sv
// Round-robin arbiter sharing one APU interconnect port between NUM_REQ dispatchers.
// An in-order FIFO of {id, waddr} routes each response back to the requester that issued it.
module riscv_apu_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0][5:0]   waddr_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        resp_valid_o,
   output logic [5:0]                resp_waddr_o,
   output logic                      apu_master_req_o,
   input  logic                      apu_master_gnt_i,
   input  logic                      apu_master_valid_i,
   output logic                      apu_master_ready_o,
   output logic [$clog2(DEPTH):0]    outstanding_o,
   output logic                      err_o
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]  winner;
   logic            found;
   int unsigned     idx;
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            err_q;
   logic [IdW-1:0]  fifo_id_q    [DEPTH];
   logic [5:0]      fifo_waddr_q [DEPTH];
   logic            full, accept, push, pop, bypass;

   // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      winner = rr_ptr_q;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NUM_REQ;
         if (!found && req_i[idx[IdW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IdW-1:0];
         end
      end
   end

   // Stall uses registered count only, so a same-cycle pop never unblocks a full FIFO.
   assign full               = (count_q == CntW'(DEPTH));
   assign apu_master_req_o   = (|req_i) & ~full;
   assign apu_master_ready_o = 1'b1;
   assign accept             = apu_master_req_o & apu_master_gnt_i;
   assign pop                = apu_master_valid_i & (count_q != '0);
   assign bypass             = apu_master_valid_i & (count_q == '0) & accept;
   assign push               = accept & ~bypass;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         gnt_o[i] = accept && (winner == IdW'(i));
      end
   end

   always_comb begin
      resp_valid_o = '0;
      resp_waddr_o = '0;
      if (pop) begin
         resp_valid_o[fifo_id_q[rd_ptr_q]] = 1'b1;
         resp_waddr_o                      = fifo_waddr_q[rd_ptr_q];
      end else if (bypass) begin
         resp_valid_o[winner] = 1'b1;
         resp_waddr_o         = waddr_i[winner];
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (apu_master_valid_i && (count_q == '0) && !accept) begin
            err_q <= 1'b1;
         end
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_id_q[wr_ptr_q]    <= winner;
         fifo_waddr_q[wr_ptr_q] <= waddr_i[winner];
      end
   end

   assign outstanding_o = count_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Directed bench for riscv_apu_arbiter; expected responses are queued at grant time and
// checked by an independent monitor whenever the DUT strobes a response.
module tb_riscv_apu_arbiter;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [3:0]     req;
   logic [3:0][5:0] waddr;
   logic           mgnt, mvalid;
   logic [3:0]     gnt_o, resp_valid_o;
   logic [5:0]     resp_waddr_o;
   logic           apu_master_req_o, apu_master_ready_o, err_o;
   logic [2:0]     outstanding_o;

   typedef struct {
      int id;
      int waddr;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total = 0;
   int   exp_cnt = 0;
   bit   exp_err = 1'b0;
   bit   exp_resp_now = 1'b0;
   bit   mon_en = 1'b0;

   riscv_apu_arbiter #(.NUM_REQ(4), .DEPTH(4)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_i              (req),
      .waddr_i            (waddr),
      .gnt_o              (gnt_o),
      .resp_valid_o       (resp_valid_o),
      .resp_waddr_o       (resp_waddr_o),
      .apu_master_req_o   (apu_master_req_o),
      .apu_master_gnt_i   (mgnt),
      .apu_master_valid_i (mvalid),
      .apu_master_ready_o (apu_master_ready_o),
      .outstanding_o      (outstanding_o),
      .err_o              (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // One clock of stimulus; gid is the hand-computed winner, -1 for no grant.
   task automatic cycle(input logic [3:0] r, input logic g, input logic v, input int gid);
      logic [3:0] eg;
      bit         byp, pp;
      exp_t       e;
      req    = r;
      mgnt   = g;
      mvalid = v;
      eg     = (gid >= 0) ? 4'(1 << gid) : 4'b0;
      @(negedge clk);
      chk("gnt", int'(gnt_o), int'(eg));
      chk("master_req", int'(apu_master_req_o), int'(r != 4'b0 && exp_cnt != 4));
      byp = (gid >= 0) && v && (exp_cnt == 0);
      pp  = v && (exp_cnt > 0);
      exp_resp_now = pp || byp;
      if (v && exp_cnt == 0 && gid < 0) exp_err = 1'b1;
      if (gid >= 0) begin
         e.id    = gid;
         e.waddr = int'(waddr[gid]);
         sb.push_back(e);
         if (!byp) exp_cnt++;
      end
      if (pp) exp_cnt--;
      @(posedge clk);
      #1;
      exp_resp_now = 1'b0;
      chk("outstanding", int'(outstanding_o), exp_cnt);
      chk("err", int'(err_o), int'(exp_err));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            chk("resp_present", int'(|resp_valid_o), int'(exp_resp_now));
            if (|resp_valid_o) begin
               if (sb.size() == 0) begin
                  total++;
                  $display("FAIL resp_unexpected: got strobe %b, expected none", resp_valid_o);
               end else begin
                  e = sb.pop_front();
                  chk("resp_id", int'(resp_valid_o), 1 << e.id);
                  chk("resp_waddr", int'(resp_waddr_o), e.waddr);
               end
            end else begin
               chk("resp_waddr_idle", int'(resp_waddr_o), 0);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin : stim
      req    = '0;
      mgnt   = 1'b0;
      mvalid = 1'b0;
      waddr  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", int'(gnt_o), 0);
      chk("rst_resp_valid", int'(resp_valid_o), 0);
      chk("rst_resp_waddr", int'(resp_waddr_o), 0);
      chk("rst_master_req", int'(apu_master_req_o), 0);
      chk("rst_ready", int'(apu_master_ready_o), 1);
      chk("rst_outstanding", int'(outstanding_o), 0);
      chk("rst_err", int'(err_o), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Round-robin fairness, responses starting two cycles after the first grant.
      for (int r = 0; r < 4; r++) waddr[r] = 6'(40 + r);
      cycle(4'b1111, 1'b1, 1'b0, 0);
      cycle(4'b1111, 1'b1, 1'b0, 1);
      for (int k = 2; k < 8; k++) cycle(4'b1111, 1'b1, 1'b1, k % 4);
      repeat (2) cycle(4'b0000, 1'b0, 1'b1, -1);

      // Full stall: four grants, then blocked until a response frees a slot.
      for (int r = 0; r < 4; r++) waddr[r] = 6'(20 + r);
      for (int k = 0; k < 4; k++) cycle(4'b1111, 1'b1, 1'b0, k);
      repeat (3) cycle(4'b1111, 1'b1, 1'b0, -1);
      cycle(4'b1111, 1'b1, 1'b1, -1);
      cycle(4'b1111, 1'b1, 1'b0, 0);
      repeat (4) cycle(4'b0000, 1'b0, 1'b1, -1);

      // Single-cycle bypass with an empty FIFO.
      waddr[2] = 6'd17;
      cycle(4'b0100, 1'b1, 1'b1, 2);

      // Simultaneous push and pop at count 2.
      for (int r = 0; r < 4; r++) waddr[r] = 6'(50 + r);
      cycle(4'b1000, 1'b1, 1'b0, 3);
      cycle(4'b0001, 1'b1, 1'b0, 0);
      cycle(4'b0010, 1'b1, 1'b1, 1);
      repeat (2) cycle(4'b0000, 1'b0, 1'b1, -1);

      // Interconnect backpressure.
      waddr[3] = 6'd33;
      repeat (3) cycle(4'b1000, 1'b0, 1'b0, -1);
      cycle(4'b1000, 1'b1, 1'b0, 3);
      cycle(4'b0000, 1'b0, 1'b1, -1);

      // Spurious response sets a sticky error.
      cycle(4'b0000, 1'b0, 1'b1, -1);
      cycle(4'b0000, 1'b0, 1'b0, -1);

      // Reset with three outstanding and rr_ptr moved to 3.
      for (int r = 0; r < 4; r++) waddr[r] = 6'(10 + r);
      cycle(4'b1111, 1'b1, 1'b0, 0);
      cycle(4'b1111, 1'b1, 1'b0, 1);
      cycle(4'b1111, 1'b1, 1'b0, 2);
      req    = '0;
      mgnt   = 1'b0;
      mon_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_err", int'(err_o), 0);
      chk("async_rst_outstanding", int'(outstanding_o), 0);
      sb.delete();
      exp_cnt = 0;
      exp_err = 1'b0;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      cycle(4'b1111, 1'b1, 1'b0, 0);
      cycle(4'b0000, 1'b0, 1'b1, -1);
      cycle(4'b0000, 1'b0, 1'b1, -1);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
